msb_restore_shifter: RTL and testbench

- Iterative right-shift denormalizer: the inverse of the leading-zero normalization step in the divider datapath.
- Takes an N-bit normalized value and a shift count in the same format the leading-zero counter produces. Returns the value shifted right by that count, plus a sticky bit (OR of all bits shifted out) for later rounding.
- Processes one binary stage of the shift per cycle, with valid/ready handshakes on both sides.

---
 rtl/msb_restore_shifter.sv | 157 +++++++++++++++
 tb/tb_msb_restore_shifter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/msb_restore_shifter.sv
// -----------------------------------------------------------------------------
// msb_restore_shifter
//
// Iterative right-shift denormalizer. It undoes the leading-zero normalization
// step of the divider datapath. The shift count uses the same encoding as the
// leading-zero counter. The block shifts x right by min(shamt, N) and also
// returns a sticky bit, which is the OR of every bit shifted out. Later
// rounding logic uses the sticky bit.
//
// Each cycle handles one binary stage of the shift. Stage k shifts by 2^k when
// bit k of the saturated amount is set. A whole operation therefore takes CW
// cycles in the SHIFT state.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream presents x/shamt
//   in_ready   block can accept a new operand (registered)
//   x          normalized value, N bits
//   shamt      right-shift amount, CW bits; values > N saturate to N
//   out_valid  y/sticky valid (registered)
//   out_ready  downstream accepts the result
//   y          x >> min(shamt, N), zero-filled from the MSB
//   sticky     OR of all bits of x shifted out
// -----------------------------------------------------------------------------
module msb_restore_shifter #(
    parameter int N  = 32,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  x,
    input  logic [CW-1:0] shamt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  y,
    output logic          sticky
);

    // Width of the stage counter. It counts from 0 to CW-1.
    localparam int SW = (CW > 1) ? $clog2(CW) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [N-1:0]   data_q;
    logic [CW-1:0]  amt_q;
    logic           sticky_q;
    logic [SW-1:0]  stage_q;
    logic [N-1:0]   y_q;
    logic           sticky_out_q;

    logic [N-1:0]   data_d;
    logic           sticky_d;
    logic           last_stage;

    // Per-stage candidates: the shifted word, and the OR of the bits that
    // leave the word in that stage. A stage of width >= N flushes everything.
    logic [N-1:0]   stage_shift [CW];
    logic [CW-1:0]  stage_lost;

    generate
        for (genvar gi = 0; gi < CW; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            if (SH >= N) begin : g_flush
                assign stage_shift[gi] = '0;
                assign stage_lost[gi]  = |data_q;
            end else begin : g_part
                assign stage_shift[gi] = data_q >> SH;
                assign stage_lost[gi]  = |data_q[SH-1:0];
            end
        end
    endgenerate

    assign last_stage = (stage_q == SW'(CW - 1));

    // Result of the current stage. The stage is a pass-through when its
    // amount bit is clear.
    always_comb begin
        data_d   = data_q;
        sticky_d = sticky_q;
        if (amt_q[stage_q]) begin
            data_d   = stage_shift[stage_q];
            sticky_d = sticky_q | stage_lost[stage_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            data_q       <= '0;
            amt_q        <= '0;
            sticky_q     <= 1'b0;
            stage_q      <= '0;
            y_q          <= '0;
            sticky_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        data_q     <= x;
                        sticky_q   <= 1'b0;
                        stage_q    <= '0;
                        // Saturate at capture so that stage CW-1 alone
                        // handles the full-width flush.
                        amt_q      <= (shamt > CW'(N)) ? CW'(N) : shamt;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end

                SHIFT: begin
                    data_q   <= data_d;
                    sticky_q <= sticky_d;
                    if (last_stage) begin
                        y_q          <= data_d;
                        sticky_out_q <= sticky_d;
                        out_valid_q  <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        stage_q <= stage_q + SW'(1);
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign sticky    = sticky_out_q;

endmodule

// File: tb/tb_msb_restore_shifter.sv
module tb_msb_restore_shifter;

    localparam int N  = 32;
    localparam int CW = 6;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [N-1:0]  x         = '0;
    logic [CW-1:0] shamt     = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [N-1:0]  y;
    logic          sticky;

    always #5 clk = ~clk;

    msb_restore_shifter #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .sticky    (sticky)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_txn    = 0;
    int          rdy_mode = 0;   // 0: ready high, 1: random, 2: stalled
    logic [N:0]  sb_q [$];       // {sticky, y} expected, in order
    logic [N:0]  mon_exp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N:0] model(input logic [N-1:0] xv, input int sh);
        int         e;
        logic [N-1:0] yv;
        logic       st;
        e = (sh > N) ? N : sh;
        if (e >= N) begin
            yv = '0;
            st = |xv;
        end else begin
            yv = xv >> e;
            st = |(xv & ((N'(1) << e) - N'(1)));
        end
        return {st, yv};
    endfunction

    // Presents one operand. It returns #1 after the accepting edge, and by
    // then x/shamt have been scrambled.
    task automatic send(input logic [N-1:0] xv, input logic [CW-1:0] sv);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        x        = xv;
        shamt    = sv;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        sb_q.push_back(model(xv, int'(sv)));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x        = $urandom;
        shamt    = CW'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain", sb_q.size(), 0);
    endtask

    // Output monitor: drives out_ready and compares every cycle that
    // out_valid is high against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom);
                default: out_ready = 1'b0;
            endcase
            if (out_valid) begin
                check("ready_valid_excl", in_ready, 0);
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    mon_exp = sb_q[0];
                    check("y", y, mon_exp[N-1:0]);
                    check("sticky", sticky, mon_exp[N]);
                    if (out_ready) begin
                        void'(sb_q.pop_front());
                        n_txn++;
                        $display("txn %0d: y=%08h sticky=%0b", n_txn, y, sticky);
                    end
                end
            end
        end
    end

    logic [N-1:0]  dir_x  [5] = '{32'hF000_0001, 32'hF000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0};
    logic [CW-1:0] dir_sh [5] = '{6'd4, 6'd4, 6'd32, 6'd63, 6'd17};

    initial begin
        int cnt;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_sticky", sticky, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency and ready turnaround, shamt = 0
        rdy_mode = 0;
        send(32'h8000_0000, 6'd0);
        check("busy_in_ready", in_ready, 0);
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            cnt = i;
            if (out_valid) break;
        end
        check("latency", cnt, CW);
        @(posedge clk);
        #1;
        check("post_hs_in_ready", in_ready, 1);
        check("post_hs_out_valid", out_valid, 0);

        // Asynchronous reset in the middle of SHIFT
        send(32'h1234_5678, 6'd5);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_y", y, 0);
        check("arst_sticky", sticky, 0);
        void'(sb_q.pop_back());
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_out", out_valid, 0);

        // Directed boundary operands
        for (int i = 0; i < 5; i++) begin
            send(dir_x[i], dir_sh[i]);
            drain();
        end

        // Output stall with ignored input pulses
        rdy_mode = 2;
        send(32'h0000_00FF, 6'd3);
        cnt = 0;
        while (!out_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("stall_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'(i % 2);
            x        = $urandom;
            shamt    = CW'($urandom);
            #1;
            check("stall_in_ready", in_ready, 0);
        end
        check("stall_y", y, 32'h0000_001F);
        check("stall_sticky", sticky, 1);
        @(negedge clk);
        in_valid = 1'b0;
        rdy_mode = 0;
        drain();
        repeat (12) @(negedge clk);
        check("stall_no_extra", out_valid, 0);

        // Random traffic with random back-pressure
        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom % 3) @(negedge clk);
            send($urandom, CW'($urandom_range(0, 40)));
        end
        drain();
        rdy_mode = 0;
        repeat (10) @(negedge clk);
        check("final_idle", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
